// File: rtl/pc_fetch_ctrl.sv
// Program counter register and instruction-fetch sequencer for the OTTER core.
// Holds the PC, issues IMEM requests at it, and captures the returned instruction.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_ADDR     = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] PC_DIN,
  input  logic        PC_WRITE,
  input  logic        IMEM_ACK,
  input  logic [31:0] IMEM_RDATA,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  output logic [31:0] PC,
  output logic [31:0] PC_PLUS_FOUR,
  output logic [31:0] IR,
  output logic        IR_VALID,
  output logic        MISALIGNED,
  output logic        FETCH_TIMEOUT
);

  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [31:0]   pc_r, pc_s;
  logic [31:0]   pend_r, pend_s;
  logic          flag_r, flag_s;
  logic [CW-1:0] cnt_r, cnt_s, cnt_inc_s;
  logic [31:0]   ir_r, ir_s;
  logic          irv_r, irv_s;
  logic          mis_r, mis_s;
  logic          tmo_r, tmo_s;
  logic          req_r, req_s;
  logic [31:0]   din_aligned_s;
  logic          din_mis_s;

  // Next-state, datapath and request computation for the fetch sequencer
  always_comb begin
    state_s       = state_r;
    pc_s          = pc_r;
    pend_s        = pend_r;
    flag_s        = flag_r;
    cnt_s         = cnt_r;
    ir_s          = ir_r;
    irv_s         = irv_r;
    mis_s         = mis_r;
    tmo_s         = tmo_r;
    din_aligned_s = PC_DIN & ~32'd3;
    din_mis_s     = (PC_DIN[1:0] != 2'b00);
    cnt_inc_s     = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + {{(CW-1){1'b0}}, 1'b1};

    case (state_r)
      ST_START: begin
        state_s = ST_FETCH;
        if (PC_WRITE) begin
          pc_s  = din_aligned_s;
          mis_s = din_mis_s;
        end else begin
          pc_s = pc_r;
        end
      end
      ST_FETCH: begin
        if (PC_WRITE && IMEM_ACK) begin
          // Newest redirect supersedes both the returned data and any pending target
          pc_s   = din_aligned_s;
          mis_s  = din_mis_s;
          flag_s = 1'b0;
          cnt_s  = {CW{1'b0}};
        end else if (PC_WRITE) begin
          pend_s = din_aligned_s;
          flag_s = 1'b1;
          mis_s  = din_mis_s;
          cnt_s  = cnt_inc_s;
          if (cnt_inc_s == CNT_MAX) begin
            tmo_s = 1'b1;
          end else begin
            tmo_s = tmo_r;
          end
        end else if (IMEM_ACK) begin
          cnt_s = {CW{1'b0}};
          if (flag_r) begin
            pc_s   = pend_r;
            flag_s = 1'b0;
          end else begin
            ir_s    = IMEM_RDATA;
            irv_s   = 1'b1;
            state_s = ST_HOLD;
          end
        end else begin
          cnt_s = cnt_inc_s;
          if (cnt_inc_s == CNT_MAX) begin
            tmo_s = 1'b1;
          end else begin
            tmo_s = tmo_r;
          end
        end
      end
      ST_HOLD: begin
        if (PC_WRITE) begin
          pc_s    = din_aligned_s;
          mis_s   = din_mis_s;
          irv_s   = 1'b0;
          state_s = ST_FETCH;
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        state_s = ST_START;
      end
    endcase

    req_s = (state_s == ST_FETCH);
  end

  // State and datapath registers; reset drops the request immediately
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= ST_START;
      pc_r    <= RESET_ADDR;
      pend_r  <= 32'h0000_0000;
      flag_r  <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      ir_r    <= 32'h0000_0000;
      irv_r   <= 1'b0;
      mis_r   <= 1'b0;
      tmo_r   <= 1'b0;
      req_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      pend_r  <= pend_s;
      flag_r  <= flag_s;
      cnt_r   <= cnt_s;
      ir_r    <= ir_s;
      irv_r   <= irv_s;
      mis_r   <= mis_s;
      tmo_r   <= tmo_s;
      req_r   <= req_s;
    end
  end

  assign IMEM_REQ      = req_r;
  assign IMEM_ADDR     = pc_r;
  assign PC            = pc_r;
  assign PC_PLUS_FOUR  = pc_r + 32'd4;
  assign IR            = ir_r;
  assign IR_VALID      = irv_r;
  assign MISALIGNED    = mis_r;
  assign FETCH_TIMEOUT = tmo_r;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: expected request addresses and fetched
// instructions are queued by the stimulus and popped by an independent monitor.
module tb_pc_fetch_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] PC_DIN;
  logic        PC_WRITE;
  logic        IMEM_ACK;
  logic [31:0] IMEM_RDATA;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic [31:0] PC;
  logic [31:0] PC_PLUS_FOUR;
  logic [31:0] IR;
  logic        IR_VALID;
  logic        MISALIGNED;
  logic        FETCH_TIMEOUT;

  int errors = 0;
  int checks = 0;

  logic [31:0] req_q[$];
  logic [31:0] ir_q[$];

  pc_fetch_ctrl #(.RESET_ADDR(32'h0000_0000), .TIMEOUT_CYCLES(4)) dut (
    .CLK(CLK), .RST(RST), .PC_DIN(PC_DIN), .PC_WRITE(PC_WRITE),
    .IMEM_ACK(IMEM_ACK), .IMEM_RDATA(IMEM_RDATA), .IMEM_REQ(IMEM_REQ),
    .IMEM_ADDR(IMEM_ADDR), .PC(PC), .PC_PLUS_FOUR(PC_PLUS_FOUR), .IR(IR),
    .IR_VALID(IR_VALID), .MISALIGNED(MISALIGNED), .FETCH_TIMEOUT(FETCH_TIMEOUT)
  );

  always #5 CLK = ~CLK;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  // Monitor: new requests and IR_VALID rising edges are matched against the queues
  logic        prev_req = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic        prev_irv = 1'b0;
  always @(negedge CLK) begin
    if (RST) begin
      prev_req = 1'b0;
      prev_irv = 1'b0;
    end else begin
      if (IMEM_REQ && (!prev_req || IMEM_ADDR != prev_addr)) begin
        if (req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req: got addr %h expected none", IMEM_ADDR);
        end else begin
          chk("req_addr", IMEM_ADDR, req_q.pop_front());
        end
      end
      if (IR_VALID && !prev_irv) begin
        if (ir_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ir: got %h expected none", IR);
        end else begin
          chk("ir_data", IR, ir_q.pop_front());
        end
      end
      prev_req  = IMEM_REQ;
      prev_addr = IMEM_ADDR;
      prev_irv  = IR_VALID;
    end
  end

  initial begin
    RST = 1'b1; PC_DIN = 32'h0; PC_WRITE = 1'b0; IMEM_ACK = 1'b0; IMEM_RDATA = 32'h0;
    tick(); tick();
    sample();
    chk("rst_pc", PC, 32'h0);
    chk("rst_ir", IR, 32'h0);
    chk("rst_irv", {31'd0, IR_VALID}, 32'd0);
    chk("rst_req", {31'd0, IMEM_REQ}, 32'd0);
    chk("rst_mis", {31'd0, MISALIGNED}, 32'd0);
    chk("rst_tmo", {31'd0, FETCH_TIMEOUT}, 32'd0);

    // 1: first fetch after reset, ACK two cycles into the request
    tick();
    RST = 1'b0;
    req_q.push_back(32'h0000_0000);
    tick();
    sample();
    chk("t1_req", {31'd0, IMEM_REQ}, 32'd1);
    tick();
    IMEM_ACK = 1'b1; IMEM_RDATA = 32'h0050_0093; ir_q.push_back(32'h0050_0093);
    tick();
    IMEM_ACK = 1'b0;
    sample();
    chk("t1_irv", {31'd0, IR_VALID}, 32'd1);
    chk("t1_pc4", PC_PLUS_FOUR, 32'h0000_0004);
    chk("t1_req_drop", {31'd0, IMEM_REQ}, 32'd0);

    // 2: redirect from HOLD
    PC_WRITE = 1'b1; PC_DIN = 32'h0000_0100; req_q.push_back(32'h0000_0100);
    tick();
    PC_WRITE = 1'b0;
    sample();
    chk("t2_pc", PC, 32'h0000_0100);
    chk("t2_irv", {31'd0, IR_VALID}, 32'd0);
    chk("t2_req", {31'd0, IMEM_REQ}, 32'd1);

    // 3: redirect while waiting; the in-flight ACK is discarded
    tick();
    PC_WRITE = 1'b1; PC_DIN = 32'h0000_0200;
    tick();
    PC_WRITE = 1'b0;
    sample();
    chk("t3_pc_hold", IMEM_ADDR, 32'h0000_0100);
    IMEM_ACK = 1'b1; IMEM_RDATA = 32'hDEAD_BEEF; req_q.push_back(32'h0000_0200);
    tick();
    IMEM_ACK = 1'b0;
    sample();
    chk("t3_ir_kept", IR, 32'h0050_0093);
    chk("t3_irv", {31'd0, IR_VALID}, 32'd0);
    chk("t3_req", {31'd0, IMEM_REQ}, 32'd1);
    IMEM_ACK = 1'b1; IMEM_RDATA = 32'h1234_5678; ir_q.push_back(32'h1234_5678);
    tick();
    IMEM_ACK = 1'b0;
    sample();
    chk("t3_irv2", {31'd0, IR_VALID}, 32'd1);

    // 4: misaligned target, then aligned pending redirect
    PC_WRITE = 1'b1; PC_DIN = 32'h0000_0102; req_q.push_back(32'h0000_0100);
    tick();
    PC_WRITE = 1'b0;
    sample();
    chk("t4_pc", PC, 32'h0000_0100);
    chk("t4_mis", {31'd0, MISALIGNED}, 32'd1);
    PC_WRITE = 1'b1; PC_DIN = 32'h0000_0104;
    tick();
    PC_WRITE = 1'b0;
    sample();
    chk("t4_mis_clr", {31'd0, MISALIGNED}, 32'd0);
    chk("t4_pc_wait", PC, 32'h0000_0100);
    IMEM_ACK = 1'b1; IMEM_RDATA = 32'h1111_1111; req_q.push_back(32'h0000_0104);
    tick();
    IMEM_RDATA = 32'h00A0_0113; ir_q.push_back(32'h00A0_0113);
    tick();
    IMEM_ACK = 1'b0;

    // 5: PC+4 wraps; then PC_WRITE and ACK in the same cycle
    PC_WRITE = 1'b1; PC_DIN = 32'hFFFF_FFFC; req_q.push_back(32'hFFFF_FFFC);
    tick();
    PC_WRITE = 1'b0;
    sample();
    chk("t5_pc4_wrap", PC_PLUS_FOUR, 32'h0000_0000);
    PC_WRITE = 1'b1; PC_DIN = 32'h0000_0300;
    IMEM_ACK = 1'b1; IMEM_RDATA = 32'hBAD0_BAD0; req_q.push_back(32'h0000_0300);
    tick();
    PC_WRITE = 1'b0; IMEM_ACK = 1'b0;
    sample();
    chk("t5_pc", PC, 32'h0000_0300);
    chk("t5_ir_kept", IR, 32'h00A0_0113);
    chk("t5_irv", {31'd0, IR_VALID}, 32'd0);

    // 6: timeout after four unanswered fetch cycles, sticky across a later ACK
    tick(); tick(); tick();
    sample();
    chk("t6_tmo_early", {31'd0, FETCH_TIMEOUT}, 32'd0);
    tick();
    sample();
    chk("t6_tmo_set", {31'd0, FETCH_TIMEOUT}, 32'd1);
    tick(); tick();
    IMEM_ACK = 1'b1; IMEM_RDATA = 32'h0000_0013; ir_q.push_back(32'h0000_0013);
    tick();
    IMEM_ACK = 1'b0;
    sample();
    chk("t6_tmo_sticky", {31'd0, FETCH_TIMEOUT}, 32'd1);
    chk("t6_ir", IR, 32'h0000_0013);

    // Reset in the middle of a fetch, with a stray ACK during reset
    PC_WRITE = 1'b1; PC_DIN = 32'h0000_0400; req_q.push_back(32'h0000_0400);
    tick();
    PC_WRITE = 1'b0;
    tick();
    RST = 1'b1;
    #1;
    chk("rst_mid_req", {31'd0, IMEM_REQ}, 32'd0);
    chk("rst_mid_pc", PC, 32'h0);
    chk("rst_mid_ir", IR, 32'h0);
    chk("rst_mid_tmo", {31'd0, FETCH_TIMEOUT}, 32'd0);
    IMEM_ACK = 1'b1; IMEM_RDATA = 32'hCAFE_F00D;
    tick();
    IMEM_ACK = 1'b0;
    sample();
    chk("rst_ack_ignored", IR, 32'h0);
    chk("rst_irv", {31'd0, IR_VALID}, 32'd0);
    tick();
    RST = 1'b0;
    req_q.push_back(32'h0000_0000);
    tick();
    sample();
    #1;
    checks++;
    if (req_q.size() != 0 || ir_q.size() != 0) begin
      errors++;
      $display("FAIL queues_drained: got req=%0d ir=%0d expected 0/0", req_q.size(), ir_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
